// File: rtl/relay_register_bank.sv
// Relay register bank: loads settle for a fixed pickup delay before commit.
// Selected registers drive a wired-OR output bus.
module relay_register_bank #(
    parameter int WIDTH   = 8,
    parameter int NUM_REG = 4,
    parameter int SETTLE  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [NUM_REG-1:0]       load,
    input  logic [NUM_REG-1:0]       sel,
    output logic [WIDTH-1:0]         bus_out,
    output logic [NUM_REG*WIDTH-1:0] reg_q,
    output logic                     busy,
    output logic                     multi_sel,
    output logic                     load_err
);

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [NUM_REG-1:0] r_mask;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_regs [NUM_REG];
    logic               r_busy;
    logic               r_load_err;
    logic               w_accept;
    logic               w_commit;
    logic               w_reject;
    logic [WIDTH-1:0]   w_bus;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_reject    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|load) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Loads arriving mid-settle, commit cycle included, are dropped
                w_reject = |load;
                if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_mask     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_load_err <= 1'b0;
            for (int i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == S_SETTLE);
            r_load_err <= w_reject;
            if (w_accept) begin
                r_mask <= load;
                r_data <= data_in;
                r_cnt  <= CNT_INIT;
            end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                for (int i = 0; i < NUM_REG; i++) begin
                    if (r_mask[i]) begin
                        r_regs[i] <= r_data;
                    end
                end
            end
        end
    end

    always_comb begin
        w_bus = '0;
        reg_q = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            reg_q[i*WIDTH +: WIDTH] = r_regs[i];
            if (sel[i]) begin
                w_bus = w_bus | r_regs[i];
            end
        end
    end

    assign bus_out   = w_bus;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi_sel = |(sel & (sel - NUM_REG'(1)));
    assign busy      = r_busy;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_relay_register_bank.sv
// Directed bench for relay_register_bank: default build plus a
// WIDTH=16 / NUM_REG=8 / SETTLE=1 build.
module tb_relay_register_bank;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic [3:0]  load;
    logic [3:0]  sel;
    logic [7:0]  bus_out;
    logic [31:0] reg_q;
    logic        busy;
    logic        multi_sel;
    logic        load_err;

    logic [15:0]  p_data_in;
    logic [7:0]   p_load;
    logic [7:0]   p_sel;
    logic [15:0]  p_bus_out;
    logic [127:0] p_reg_q;
    logic         p_busy;
    logic         p_multi_sel;
    logic         p_load_err;

    int checks;
    int errors;

    relay_register_bank dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .load      (load),
        .sel       (sel),
        .bus_out   (bus_out),
        .reg_q     (reg_q),
        .busy      (busy),
        .multi_sel (multi_sel),
        .load_err  (load_err)
    );

    relay_register_bank #(
        .WIDTH   (16),
        .NUM_REG (8),
        .SETTLE  (1)
    ) dut_p (
        .clk       (clk),
        .reset     (reset),
        .data_in   (p_data_in),
        .load      (p_load),
        .sel       (p_sel),
        .bus_out   (p_bus_out),
        .reg_q     (p_reg_q),
        .busy      (p_busy),
        .multi_sel (p_multi_sel),
        .load_err  (p_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        data_in   = '0;
        load      = '0;
        sel       = 4'b1111;
        p_data_in = '0;
        p_load    = '0;
        p_sel     = '0;
        tick();
        tick();
        chk("rst_regq", reg_q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", load_err, 0);
        chk("rst_bus", bus_out, 0);
        chk("rst_multi", multi_sel, 1);
        reset = 1'b0;
        sel   = 4'b0001;
        #1;
        chk("rst_multi_off", multi_sel, 0);

        // basic load, SETTLE=2
        load    = 4'b0001;
        data_in = 8'h5A;
        tick();
        load    = 4'b0000;
        data_in = 8'h00;
        chk("basic_busy_k", busy, 1);
        chk("basic_bus_k", bus_out, 0);
        tick();
        chk("basic_busy_k1", busy, 1);
        chk("basic_regq_k1", reg_q, 0);
        tick();
        chk("basic_busy_k2", busy, 0);
        chk("basic_regq_k2", reg_q, 32'h0000_005A);
        chk("basic_bus_k2", bus_out, 8'h5A);

        // multi-load and wired-OR
        load    = 4'b0110;
        data_in = 8'h0F;
        tick();
        load = 4'b0000;
        tick();
        tick();
        load    = 4'b1000;
        data_in = 8'hF0;
        tick();
        load = 4'b0000;
        tick();
        tick();
        chk("multi_regq", reg_q, 32'hF00F_0F5A);
        sel = 4'b1100;
        #1;
        chk("or_bus", bus_out, 8'hFF);
        chk("or_multi", multi_sel, 1);
        sel = 4'b0010;
        #1;
        chk("or_bus_one", bus_out, 8'h0F);
        chk("or_multi_one", multi_sel, 0);
        sel = 4'b0000;
        #1;
        chk("or_bus_none", bus_out, 0);

        // rejected load
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rej_clear", reg_q, 0);
        load    = 4'b0001;
        data_in = 8'h11;
        tick();
        load    = 4'b0010;
        data_in = 8'h22;
        tick();
        load = 4'b0000;
        chk("rej_err_hi", load_err, 1);
        chk("rej_busy", busy, 1);
        tick();
        chk("rej_err_lo", load_err, 0);
        chk("rej_regq", reg_q, 32'h0000_0011);
        chk("rej_idle", busy, 0);

        // load during the commit cycle is also dropped
        load    = 4'b0001;
        data_in = 8'h33;
        tick();
        load = 4'b0000;
        tick();
        load    = 4'b0100;
        data_in = 8'h77;
        tick();
        load = 4'b0000;
        chk("cmt_rej_err", load_err, 1);
        chk("cmt_rej_busy", busy, 0);
        chk("cmt_rej_regq", reg_q, 32'h0000_0033);
        tick();
        chk("cmt_rej_err_lo", load_err, 0);
        chk("cmt_rej_busy2", busy, 0);
        chk("cmt_rej_regq2", reg_q, 32'h0000_0033);

        // mid-settle reset
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        load    = 4'b0001;
        data_in = 8'hAA;
        tick();
        load  = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_regq", reg_q, 0);
        chk("mrst_busy", busy, 0);
        tick();
        tick();
        tick();
        chk("mrst_regq_late", reg_q, 0);
        chk("mrst_busy_late", busy, 0);

        // reset wins over a simultaneous load
        load    = 4'b0010;
        data_in = 8'h99;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        load  = 4'b0000;
        chk("rprio_busy", busy, 0);
        tick();
        tick();
        chk("rprio_regq", reg_q, 0);

        // old-value visibility
        load    = 4'b0100;
        data_in = 8'h33;
        tick();
        load = 4'b0000;
        tick();
        tick();
        sel = 4'b0100;
        #1;
        chk("old_pre", bus_out, 8'h33);
        load    = 4'b0100;
        data_in = 8'h44;
        tick();
        load = 4'b0000;
        chk("old_busy", busy, 1);
        chk("old_bus_k", bus_out, 8'h33);
        tick();
        chk("old_bus_k1", bus_out, 8'h33);
        tick();
        chk("old_bus_new", bus_out, 8'h44);
        chk("old_idle", busy, 0);

        // WIDTH=16 NUM_REG=8 SETTLE=1
        chk("p_rst", p_reg_q, 0);
        p_load    = 8'h80;
        p_data_in = 16'hBEEF;
        tick();
        p_load    = 8'h00;
        p_data_in = 16'h0000;
        chk("p_busy_k", p_busy, 1);
        chk("p_regq_k", p_reg_q, 0);
        tick();
        chk("p_busy_k1", p_busy, 0);
        chk("p_top", p_reg_q[127:112], 16'hBEEF);
        chk("p_regq", p_reg_q, {16'hBEEF, 112'd0});
        p_sel = 8'h80;
        #1;
        chk("p_bus", p_bus_out, 16'hBEEF);
        chk("p_err", p_load_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
